deadlock_idx0_monitor: RTL and testbench
========================================

# deadlock_idx0_monitor

Per-kernel deadlock detector for the top-level kernel (index 0) of a simulated HLS design. It watches the kernel's AXI-Stream blocking flags and the idle/blocked flags of its sub-instances. When a blocked condition persists unchanged for a programmable number of cycles, it raises a sticky `block` flag. It sits inside the kernel-level deadlock monitor, which feeds it inverted `*_blk_n` signals and tie-offs.

## Interface
Parameters:
- `N_AXIS`, default 2: number of AXI-Stream channel blocking flags.
- `N_INST`, default 1: number of sub-instance idle/block flag pairs.
- `DEADLOCK_CYCLES`, default 1000: consecutive unchanged blocked cycles required to declare deadlock. Legal range is ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `axis_block_sigs`  in  N_AXIS  bit i = 1: AXIS channel i is blocked (stalled on TDATA handshake).
- `inst_idle_sigs`  in  N_INST  bit j = 1: sub-instance j is idle.
- `inst_block_sigs`  in  N_INST  bit j = 1: sub-instance j is blocked.
- `block`  out  1  registered, sticky deadlock flag.

## Operation
- Snapshot vector `snap` = {inst_idle_sigs, inst_block_sigs, axis_block_sigs}, width N_AXIS+2·N_INST.
- Candidate is `cand = |axis_block_sigs | |inst_block_sigs`. Idle bits never create a candidate; they only form part of the snapshot.
- Registers:
  - `prev_snap`: width of `snap`.
  - `cnt`: width $clog2(DEADLOCK_CYCLES+1), saturating.
  - `block`.
- Every rising edge:
  - If !cand, then cnt_next = 0.
  - Else if snap ≠ prev_snap, then cnt_next = 1.
  - Else cnt_next = min(cnt+1, DEADLOCK_CYCLES).
  - cnt <= cnt_next; prev_snap <= snap.
  - block <= block | (cnt_next == DEADLOCK_CYCLES).
- `block` is sticky. Once set, it stays 1 until `reset`, regardless of inputs.
- Any change of any snapshot bit, including idle bits, restarts the count at 1 when cand holds, or at 0 when it does not.
- Tie-off case (inst signals all 0): detection depends only on the AXIS flags.

## Timing
- Reset (asynchronous assert, synchronous-clean release): block=0, cnt=0, prev_snap=0.
- Reset asserted mid-count or after detection clears everything immediately. Counting restarts from the first post-reset edge.
- Latency: if cand holds with identical snap on edges e1..eN (N=DEADLOCK_CYCLES), block is 1 immediately after eN. With DEADLOCK_CYCLES=1, block rises on the first edge sampling cand.
- The counter saturates at DEADLOCK_CYCLES; there is no wrap-around.
- Inputs are sampled only at rising edges. Glitches between edges are ignored.
- There is no handshake. The output is level, combinationally independent of the inputs.

## Structure
- A shared package `deadlock_mon_pkg` holds the default DEADLOCK_CYCLES constant and a function computing counter width.
- Optional sub-module `stable_cycle_counter`, generic over width: its input is cand plus the change flag, and its output is reached = (cnt_next == limit). The top keeps the snapshot logic and the sticky flag.
- No other state; no FSM beyond counter plus sticky bit.

## Test plan
All scenarios use DEADLOCK_CYCLES=4, N_AXIS=2, N_INST=1.
- Reset, then all inputs 0 for 20 cycles -> block stays 0 and cnt stays 0.
- axis_block_sigs=2'b01 held for 4 edges -> block=1 right after the 4th edge. Then inputs go 0 -> block remains 1.
- axis_block_sigs=2'b01 for 3 edges, then 2'b10 for 3 edges, then 2'b00 -> block stays 0 (count restarts at 1 on the change).
- axis_block_sigs=2'b11, with inst_idle_sigs toggling every 2 cycles for 12 cycles -> block stays 0. Then idle held for 4 edges -> block=1.
- inst_block_sigs=1, axis=0 held for 4 edges -> block=1. Assert reset asynchronously mid-cycle -> block=0 immediately, before the next edge.
- DEADLOCK_CYCLES=1 variant: a single sampled axis_block_sigs=2'b10 -> block=1 after that edge.

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
// -----------------------------------------------------------------------------
// deadlock_mon_pkg
// Shared constants and helpers for the kernel deadlock monitors.
//   DEFAULT_DEADLOCK_CYCLES : default stable-blocked cycle threshold
//   cnt_width()             : counter width able to hold 0..limit
// -----------------------------------------------------------------------------
package deadlock_mon_pkg;

  localparam int unsigned DEFAULT_DEADLOCK_CYCLES = 32'd1000;

  // Width of a counter that must represent every value 0..limit (limit >= 1).
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    if (limit < 32'd1) begin
      w = 32'd1;
    end else begin
      w = $clog2(limit + 32'd1);
    end
    return w;
  endfunction

endpackage : deadlock_mon_pkg

// File: rtl/stable_cycle_counter.sv
// -----------------------------------------------------------------------------
// stable_cycle_counter
// Counts consecutive edges on which a candidate condition holds with an
// unchanged snapshot. Saturates at LIMIT and reports when the next count
// value equals LIMIT.
// Ports:
//   clock     in  rising-edge clock
//   reset     in  asynchronous active-high reset
//   cand_i    in  candidate condition sampled this edge
//   changed_i in  snapshot differs from the previous sampled snapshot
//   reached_o out next count value equals LIMIT (combinational)
// -----------------------------------------------------------------------------
module stable_cycle_counter
  import deadlock_mon_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_DEADLOCK_CYCLES,
  parameter int unsigned CNT_W = cnt_width(LIMIT)
) (
  input  logic clock,
  input  logic reset,
  input  logic cand_i,
  input  logic changed_i,
  output logic reached_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: cleared without a candidate, restarted on any snapshot
  // change, otherwise advanced and held at LIMIT (no wrap-around).
  always_comb begin
    cnt_d = '0;
    if (!cand_i) begin
      cnt_d = '0;
    end else if (changed_i) begin
      cnt_d = ONE_C;
    end else if (cnt_q >= LIMIT_C) begin
      cnt_d = LIMIT_C;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached_o = (cnt_d == LIMIT_C);

endmodule : stable_cycle_counter

// File: rtl/deadlock_idx0_monitor.sv
// -----------------------------------------------------------------------------
// deadlock_idx0_monitor
// Deadlock detector for the top-level kernel (index 0). Raises a sticky
// block flag once a blocked condition persists with an unchanged snapshot of
// all watched flags for DEADLOCK_CYCLES consecutive edges.
// Ports:
//   clock           in  rising-edge clock
//   reset           in  asynchronous active-high reset
//   axis_block_sigs in  [N_AXIS]  AXIS channel blocked flags
//   inst_idle_sigs  in  [N_INST]  sub-instance idle flags
//   inst_block_sigs in  [N_INST]  sub-instance blocked flags
//   block           out registered sticky deadlock flag
// -----------------------------------------------------------------------------
module deadlock_idx0_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int unsigned N_AXIS          = 32'd2,
  parameter int unsigned N_INST          = 32'd1,
  parameter int unsigned DEADLOCK_CYCLES = DEFAULT_DEADLOCK_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block
);

  localparam int unsigned SNAP_W = N_AXIS + 2 * N_INST;

  logic [SNAP_W-1:0] snap_s;
  logic [SNAP_W-1:0] prev_snap_d;
  logic [SNAP_W-1:0] prev_snap_q;
  logic              cand_s;
  logic              changed_s;
  logic              reached_s;
  logic              block_d;
  logic              block_q;

  // Idle bits take part in change detection but never form a candidate.
  assign snap_s    = {inst_idle_sigs, inst_block_sigs, axis_block_sigs};
  assign cand_s    = (|axis_block_sigs) | (|inst_block_sigs);
  assign changed_s = (snap_s != prev_snap_q);

  stable_cycle_counter #(
    .LIMIT (DEADLOCK_CYCLES),
    .CNT_W (cnt_width(DEADLOCK_CYCLES))
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .cand_i    (cand_s),
    .changed_i (changed_s),
    .reached_o (reached_s)
  );

  // Next snapshot and sticky flag; once set, block only clears on reset.
  always_comb begin
    prev_snap_d = snap_s;
    block_d     = block_q | reached_s;
  end

  // Snapshot history and deadlock flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_snap_q <= '0;
      block_q     <= 1'b0;
    end else begin
      prev_snap_q <= prev_snap_d;
      block_q     <= block_d;
    end
  end

  assign block = block_q;

endmodule : deadlock_idx0_monitor

// File: tb/tb_deadlock_idx0_monitor.sv
// Scoreboard bench: a reference model predicts block for a DEADLOCK_CYCLES=4
// instance and a DEADLOCK_CYCLES=1 instance driven with identical inputs.
module tb_deadlock_idx0_monitor;

  logic       clock;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [0:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       block4;
  logic       block1;

  int vec_cnt;
  int err_cnt;

  // expected {block1, block4} after each driven edge
  logic [1:0] exp_q[$];

  // reference model state
  logic [3:0] m_prev;
  int         m_run;
  logic       m_blk4;
  logic       m_blk1;

  deadlock_idx0_monitor #(
    .N_AXIS(2), .N_INST(1), .DEADLOCK_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .block(block4)
  );

  deadlock_idx0_monitor #(
    .N_AXIS(2), .N_INST(1), .DEADLOCK_CYCLES(1)
  ) dut1 (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .block(block1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 4'b0000;
    m_run  = 0;
    m_blk4 = 1'b0;
    m_blk1 = 1'b0;
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic drive(input string tag, input logic [1:0] axis, input logic idle, input logic iblk);
    logic [3:0] snap;
    logic       cand;
    logic [1:0] exp;
    axis_block_sigs = axis;
    inst_idle_sigs  = idle;
    inst_block_sigs = iblk;
    snap = {idle, iblk, axis};
    cand = (axis != 2'b00) || iblk;
    if (!cand)              m_run = 0;
    else if (snap != m_prev) m_run = 1;
    else                    m_run = m_run + 1;
    m_prev = snap;
    if (m_run >= 4) m_blk4 = 1'b1;
    if (m_run >= 1) m_blk1 = 1'b1;
    exp_q.push_back({m_blk1, m_blk4});
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    check_eq({tag, "_blk4"}, {31'd0, block4}, {31'd0, exp[0]});
    check_eq({tag, "_blk1"}, {31'd0, block1}, {31'd0, exp[1]});
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #2;
    check_eq({tag, "_rst4"}, {31'd0, block4}, 32'd0);
    check_eq({tag, "_rst1"}, {31'd0, block1}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    axis_block_sigs = 2'b00;
    inst_idle_sigs  = 1'b0;
    inst_block_sigs = 1'b0;
    reset = 1'b1;
    model_reset();
    #12;
    check_eq("por_blk4", {31'd0, block4}, 32'd0);
    reset = 1'b0;

    // all inputs quiet
    for (int i = 0; i < 20; i++) drive("idle", 2'b00, 1'b0, 1'b0);

    // steady single channel blocked; held past saturation, then released
    for (int i = 0; i < 3; i++) drive("ax01_pre", 2'b01, 1'b0, 1'b0);
    drive("ax01_4th", 2'b01, 1'b0, 1'b0);
    check_eq("ax01_set", {31'd0, block4}, 32'd1);
    for (int i = 0; i < 8; i++) drive("ax01_sat", 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive("sticky", 2'b00, 1'b0, 1'b0);
    check_eq("sticky_hold", {31'd0, block4}, 32'd1);
    do_reset("r1");

    // channel change restarts the count
    for (int i = 0; i < 3; i++) drive("ax01_3", 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive("ax10_3", 2'b10, 1'b0, 1'b0);
    drive("ax00", 2'b00, 1'b0, 1'b0);
    check_eq("chg_noblk", {31'd0, block4}, 32'd0);
    do_reset("r2");

    // idle toggling every 2 cycles keeps restarting, then idle held
    for (int i = 0; i < 12; i++) drive("idle_tog", 2'b11, 1'((i / 2) % 2), 1'b0);
    check_eq("tog_noblk", {31'd0, block4}, 32'd0);
    for (int i = 0; i < 4; i++) drive("idle_hold", 2'b11, 1'b0, 1'b0);
    check_eq("hold_set", {31'd0, block4}, 32'd1);
    do_reset("r3");

    // sub-instance blocked alone, then async reset after detection
    for (int i = 0; i < 4; i++) drive("iblk", 2'b00, 1'b0, 1'b1);
    check_eq("iblk_set", {31'd0, block4}, 32'd1);
    do_reset("r4");

    // idle bits alone never create a candidate
    for (int i = 0; i < 6; i++) drive("idle_only", 2'b00, 1'b1, 1'b0);

    // single sampled blocked cycle trips only the 1-cycle instance
    drive("one_shot", 2'b10, 1'b0, 1'b0);
    check_eq("dc1_set", {31'd0, block1}, 32'd1);
    drive("one_off", 2'b00, 1'b0, 1'b0);

    // reset asserted mid-count, counting restarts after release
    for (int i = 0; i < 2; i++) drive("mid", 2'b01, 1'b0, 1'b0);
    do_reset("r5");
    for (int i = 0; i < 3; i++) drive("post_rst", 2'b01, 1'b0, 1'b0);
    check_eq("post_rst_0", {31'd0, block4}, 32'd0);
    drive("post_rst4", 2'b01, 1'b0, 1'b0);

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_deadlock_idx0_monitor
